// File: rtl/score_display_driver.sv
// Score display engine: latches a binary score, converts it to BCD with a
// bit-serial double-dabble FSM and scans the digits onto shared seg/an lines
// with leading-zero blanking, per-digit decimal points and overflow saturation.
//
//   state | meaning
//   IDLE  | display stable, waiting for a load strobe
//   SHIFT | double-dabble in progress, one binary bit per cycle
module score_display_driver #(
  parameter int DIGITS     = 4,
  parameter int VALUE_W    = 14,
  parameter int SCAN_DIV   = 100000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               blank_lz,
  input  logic [DIGITS-1:0]  dp_mask,
  output logic [7:0]         seg,
  output logic [DIGITS-1:0]  an,
  output logic               busy,
  output logic               overflow
);

  function automatic logic [31:0] max_decimal(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

  function automatic logic [6:0] seven_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  localparam logic [31:0] MAX_DEC = max_decimal(DIGITS);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam bit INV   = (ACTIVE_LOW != 0);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state_q, state_d;
  logic   load_accept;

  logic [VALUE_W-1:0]       bin_q;
  logic [BCD_W-1:0]         bcd_q;
  logic [BCD_W-1:0]         bcd_adj;
  logic [BCD_W+VALUE_W-1:0] shift_w;
  logic [BCD_W-1:0]         disp_q;
  logic [CNT_W-1:0]         iter_q;
  logic                     ovf_pending;
  logic                     last_iter;

  logic [PRE_W-1:0]  presc_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DIGITS-1:0] blank_vec;
  logic [3:0]        nib_sel;
  logic [7:0]        seg_hi;
  logic [DIGITS-1:0] an_hi;
  logic              all_zero;

  assign busy      = (state_q == SHIFT);
  assign last_iter = (iter_q == CNT_W'(VALUE_W - 1));

  // Add-3 correction on every BCD nibble that would overflow after doubling.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
  end

  assign shift_w = {bcd_adj, bin_q} << 1;

  // Conversion FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Conversion FSM next-state logic.
  always_comb begin
    state_d     = state_q;
    load_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d     = SHIFT;
          load_accept = 1'b1;
        end
      end
      SHIFT: begin
        if (last_iter) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Conversion datapath; the display register only changes on the final shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q       <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
      ovf_pending <= 1'b0;
      disp_q      <= '0;
      overflow    <= 1'b0;
    end else if (load_accept) begin
      bin_q       <= value;
      bcd_q       <= '0;
      iter_q      <= '0;
      ovf_pending <= (32'(value) > MAX_DEC);
    end else if (busy) begin
      bin_q  <= shift_w[VALUE_W-1:0];
      bcd_q  <= shift_w[BCD_W+VALUE_W-1:VALUE_W];
      iter_q <= iter_q + CNT_W'(1);
      if (last_iter) begin
        disp_q   <= ovf_pending ? {DIGITS{4'h9}} : shift_w[BCD_W+VALUE_W-1:VALUE_W];
        overflow <= ovf_pending;
      end
    end
  end

  // Scan prescaler and digit index, free-running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    all_zero  = 1'b1;
    blank_vec = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (disp_q[4*i +: 4] == 4'd0);
      if (i != 0) blank_vec[i] = all_zero;
    end
  end

  // Active-high pattern for the digit currently selected by the scanner.
  always_comb begin
    nib_sel = disp_q[{idx_q, 2'b00} +: 4];
    seg_hi  = {dp_mask[idx_q],
               (blank_lz && blank_vec[idx_q]) ? 7'h00 : seven_seg(nib_sel)};
    an_hi   = DIGITS'(1) << idx_q;
  end

  // Registered pin drivers, optionally inverted for common-anode boards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= INV ? 8'hC0 : 8'h3F;
      an  <= INV ? ~DIGITS'(1) : DIGITS'(1);
    end else begin
      seg <= INV ? ~seg_hi : seg_hi;
      an  <= INV ? ~an_hi : an_hi;
    end
  end

endmodule

// File: tb/tb_score_display_driver.sv
// Scoreboard bench for score_display_driver: the driver pushes the expected
// displayed score for each accepted load; a monitor pops it when busy falls
// and checks a full scanned frame against a decimal reference model.
module tb_score_display_driver;
  localparam int DIGITS   = 4;
  localparam int VALUE_W  = 14;
  localparam int SCAN_DIV = 4;
  localparam int MAXV     = 9999;

  typedef struct {
    int         val;
    bit         blank;
    logic [3:0] dp;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [VALUE_W-1:0] value = '0;
  logic               load = 1'b0;
  logic               blank_lz = 1'b0;
  logic [DIGITS-1:0]  dp_mask = '0;
  logic [7:0]         seg;
  logic [DIGITS-1:0]  an;
  logic               busy;
  logic               overflow;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  score_display_driver #(
    .DIGITS(DIGITS), .VALUE_W(VALUE_W), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
    .dp_mask(dp_mask), .seg(seg), .an(an), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [7:0] model_seg(input int v, input bit blank,
                                           input logic [3:0] dp, input int d);
    int         p;
    int         dv;
    logic [6:0] pat;
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    dv  = (v / p) % 10;
    pat = (blank && d >= 1 && (v / p) == 0) ? 7'h00 : tbl[dv];
    return ~{dp[d], pat};
  endfunction

  // Observe one full frame and compare each lit digit against the model.
  task automatic check_frame(input int raw, input bit blank, input logic [3:0] dp,
                             input string tag);
    int       v;
    int       idx;
    bit [3:0] seen;
    logic [3:0] anh;
    v    = (raw > MAXV) ? MAXV : raw;
    seen = '0;
    chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, raw > MAXV});
    for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
      @(negedge clk);
      anh = ~an;
      if (!$onehot(anh)) begin
        chk({tag, "_an_onehot"}, {28'd0, an}, 32'hE);
      end else begin
        idx = 0;
        for (int j = 0; j < DIGITS; j++) if (anh[j]) idx = j;
        seen[idx] = 1'b1;
        chk($sformatf("%s_seg_d%0d", tag, idx), {24'd0, seg},
            {24'd0, model_seg(v, blank, dp, idx)});
      end
    end
    chk({tag, "_all_digits_scanned"}, {28'd0, seen}, 32'hF);
  endtask

  // Monitor: measures busy length and checks the display after each completion.
  initial begin
    int   busy_cnt;
    bit   prev;
    exp_t e;
    busy_cnt = 0;
    prev     = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0;
        prev     = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (prev && !busy) begin
          chk("busy_length", busy_cnt, VALUE_W);
          busy_cnt = 0;
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_completion actual=1 required=0");
          end else begin
            e = sb.pop_front();
            @(negedge clk);
            check_frame(e.val, e.blank, e.dp, $sformatf("val%0d", e.val));
          end
        end
        prev = busy;
      end
    end
  end

  task automatic do_load(input int v, input bit blank, input logic [3:0] dp,
                         input bit push);
    exp_t e;
    blank_lz = blank;
    dp_mask  = dp;
    value    = VALUE_W'(v);
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    if (push) begin
      e.val = v; e.blank = blank; e.dp = dp;
      sb.push_back(e);
    end
  endtask

  // Wait for the conversion to finish and for the monitor's frame check.
  task automatic wait_done();
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_checks++;
      $display("FAIL busy_timeout actual=busy required=idle");
    end
    repeat (DIGITS * SCAN_DIV + 4) @(negedge clk);
  endtask

  task automatic conv(input int v, input bit blank, input logic [3:0] dp);
    do_load(v, blank, dp, 1'b1);
    wait_done();
  endtask

  initial begin
    int         v;
    bit         b;
    logic [3:0] d;

    // Reset state and scan order straight out of reset.
    repeat (3) @(negedge clk);
    chk("rst_an", {28'd0, an}, 32'hE);
    chk("rst_seg", {24'd0, seg}, 32'hC0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("scan_an_k%0d", k), {28'd0, an},
          {28'd0, ~(4'b0001 << (((k - 1) / SCAN_DIV) % DIGITS))});
    end

    conv(1234, 1'b0, 4'b0000);
    conv(42, 1'b1, 4'b0000);
    conv(0, 1'b1, 4'b0000);
    conv(0, 1'b1, 4'b0100);
    conv(12000, 1'b0, 4'b0000);
    conv(9999, 1'b0, 4'b0000);
    conv(10000, 1'b1, 4'b1010);
    conv(16383, 1'b0, 4'b0000);

    // Load while busy is dropped.
    do_load(5678, 1'b0, 4'b0000, 1'b1);
    repeat (2) @(negedge clk);
    value = VALUE_W'(1111);
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_done();

    // Reset mid-conversion aborts and leaves the display at zero.
    do_load(777, 1'b0, 4'b0000, 1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    check_frame(0, 1'b0, 4'b0000, "after_abort");
    conv(777, 1'b0, 4'b0000);

    // Randomised loads, biased toward small values to exercise blanking.
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 2))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 9999);
        default: v = $urandom_range(0, 16383);
      endcase
      b = 1'($urandom_range(0, 1));
      d = 4'($urandom_range(0, 15));
      conv(v, b, d);
    end

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/score_display_driver.md
# score_display_driver

Parametrised score-display engine for the multiplexed seven-segment display. It latches a binary score on a load strobe and converts it to BCD with a sequential double-dabble FSM, one bit per cycle. It then scans the digits onto the shared segment and anode lines, with optional leading-zero blanking, per-digit decimal points and overflow saturation. It sits between the board state logic's score output and the board's `seg`/`an` pins.

## Interface
- `DIGITS`, 4: number of display digits; legal range 1..8.
- `VALUE_W`, 14: width of the binary input value; legal range 1..27.
- `SCAN_DIV`, 100000: clock cycles each digit stays lit; must be at least 2.
- `ACTIVE_LOW`, 1: 1 inverts `seg` and `an` at the output (common-anode board); 0 drives them active-high.
- `clk`  in  1: single system clock; every register is clocked by it.
- `reset`  in  1: asynchronous, active-high; returns every register to its reset value.
- `value`  in  VALUE_W: unsigned binary score, sampled only when a load is accepted.
- `load`  in  1: single-cycle strobe requesting a conversion.
- `blank_lz`  in  1: leading-zero blanking enable, used live by the scanner.
- `dp_mask`  in  DIGITS: decimal-point enable per digit; bit i belongs to digit i; used live.
- `seg`  out  8: bit 0 = a, bits 1..6 = b..g, bit 7 = dp. Registered.
- `an`  out  DIGITS: one-hot digit enable; bit 0 is the rightmost digit. Registered.
- `busy`  out  1: high while a conversion is in progress.
- `overflow`  out  1: high while the displayed value is saturated.

## Operation
- Conversion FSM has two states, IDLE and SHIFT.
- IDLE, `load`=1 at a clock edge:
  - Captures `value` into the shift register.
  - Clears the BCD accumulator (4*DIGITS bits).
  - Sets `ovf_pending` = (`value` > 10^DIGITS−1), using a parameter-derived constant.
  - Sets the iteration count to 0, raises `busy` and moves to SHIFT.
- SHIFT, each edge:
  - Adds 3 to every BCD nibble that is ≥5.
  - Shifts {BCD, binary} left by one and increments the iteration count.
  - On the edge performing iteration VALUE_W−1, the shifted BCD result is written to the display register in the same edge, `busy` falls and the FSM returns to IDLE.
  - At that same edge, if `ovf_pending` is set, the display register is loaded with all 9s instead and `overflow` is set to 1. Otherwise `overflow` is cleared.
- `load` in SHIFT is ignored; no queueing. `value` changes during SHIFT have no effect.
- Display register and `overflow` keep their values until the next conversion completes.
- Scanner:
  - A prescaler counts 0..SCAN_DIV−1 continuously and wraps.
  - On wrap, the digit index advances 0→1→…→DIGITS−1→0.
  - Runs independently of the conversion FSM.
- Active-high segment patterns, one per digit value (dp clear):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66.
  - 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
- Blanking: digit i (i ≥ 1) is blanked, with segments a–g off, when `blank_lz`=1 and display nibbles i..DIGITS−1 are all zero.
- Digit 0 is never blanked. A decimal point still lights on a blanked digit if its `dp_mask` bit is set.
- `seg` register = pattern for the current index, with bit 7 = `dp_mask`[index]. `an` register = one-hot of the index. Both are inverted when ACTIVE_LOW=1.

## Timing
- Reset values (ACTIVE_LOW=1):
  - `busy`=0, `overflow`=0, FSM in IDLE.
  - Display register all zero, prescaler 0, index 0.
  - `an` = all ones except bit 0 = 0; `seg` = C0 (digit 0 showing "0").
- Reset is asynchronous. Asserting it mid-conversion aborts the conversion and returns every register to its reset value; the display register is not updated.
- Load accepted at edge N:
  - `busy`=1 after edge N.
  - Result is in the display register and `busy`=0 after edge N+VALUE_W, i.e. `busy` is high for exactly VALUE_W cycles.
  - `load` at edge N+VALUE_W is ignored. `load` at edge N+VALUE_W+1 is accepted.
- `seg`/`an` update one edge after the index changes or the display register changes; there is no other pipeline delay.
- `blank_lz` and `dp_mask` take effect at the next `seg` register update.
- Each digit is active for exactly SCAN_DIV cycles. One full frame is DIGITS×SCAN_DIV cycles.

## Test plan
All scenarios use DIGITS=4, VALUE_W=14, SCAN_DIV=4, ACTIVE_LOW=1, `dp_mask`=0 unless stated.
- Reset check: hold `reset` high → `an`=1110, `seg`=C0, `busy`=0, `overflow`=0. Release reset → `an` cycles 1110, 1101, 1011, 0111, each for 4 cycles.
- Basic conversion: load 1234 → `busy` high for 14 cycles, then digits 3..0 = 1, 2, 3, 4. Scanned `seg`, digit 0..3: 99, B0, A4, F9.
- Leading-zero blanking: `blank_lz`=1, load 42 → digits 3 and 2 show FF, digit 1 shows 99, digit 0 shows A4.
  - Load 0 → digits 1..3 show FF, digit 0 shows C0.
  - Set `dp_mask`=0100 → digit 2 shows 7F.
- Overflow saturation: load 12000 → all digits show 90, `overflow`=1. Then load 9999 → all digits show 90, `overflow`=0.
- Load while busy: load 5678, pulse `load` with 1111 three cycles later → 5678 is displayed. The second load is lost and `busy` is high for only 14 cycles.
- Reset mid-conversion: load 777, assert `reset` 5 cycles later → display register stays 0, `busy`=0. The next load of 777 completes normally.
